// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search sequencer: walks candidate keys through S-memory init, KSA shuffle
// and decrypt, owns the shared S-memory port, and screens decrypted bytes for text.
module rc4_key_search_ctrl #(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_FIRST = KEY_W'(24'h000000),
  parameter logic [KEY_W-1:0] KEY_LAST  = KEY_W'(24'h3FFFFF),
  parameter int               TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             init_start,
  input  logic             init_done,
  output logic             shuf_start,
  input  logic             shuf_done,
  output logic             dec_start,
  input  logic             dec_done,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_data,
  input  logic             init_wren,
  input  logic [7:0]       shuf_addr,
  input  logic [7:0]       shuf_data,
  input  logic             shuf_wren,
  input  logic [7:0]       dec_addr,
  input  logic [7:0]       dec_data,
  input  logic             dec_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_data,
  output logic             s_wren,
  input  logic             d_wren,
  input  logic [7:0]       d_data,
  output logic [KEY_W-1:0] secret_key,
  output logic             busy,
  output logic             found,
  output logic             failed,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    IDLE, INIT, SHUF, DEC, CHECK, NEXT, FOUND, FAIL
  } state_t;

  localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WDOG_W-1:0]  wdog_q;
  logic [KEY_W-1:0]   key_q;
  logic               bad_char_q;
  logic               timeout_q;
  logic               init_start_q, shuf_start_q, dec_start_q;
  logic               start_accept;
  logic               wdog_trip;
  logic               in_phase;
  logic               wdog_at_limit;

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  assign in_phase      = (state_q == INIT) || (state_q == SHUF) || (state_q == DEC);
  assign wdog_at_limit = (wdog_q == WDOG_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d      = state_q;
    start_accept = 1'b0;
    wdog_trip    = 1'b0;
    case (state_q)
      IDLE, FOUND, FAIL: begin
        if (start) begin
          state_d      = INIT;
          start_accept = 1'b1;
        end
      end
      INIT: begin
        if (init_done) state_d = SHUF;
        else if (wdog_at_limit) begin
          state_d   = FAIL;
          wdog_trip = 1'b1;
        end
      end
      SHUF: begin
        if (shuf_done) state_d = DEC;
        else if (wdog_at_limit) begin
          state_d   = FAIL;
          wdog_trip = 1'b1;
        end
      end
      DEC: begin
        if (dec_done) state_d = CHECK;
        else if (wdog_at_limit) begin
          state_d   = FAIL;
          wdog_trip = 1'b1;
        end
      end
      CHECK: begin
        if (!bad_char_q)             state_d = FOUND;
        else if (key_q == KEY_LAST)  state_d = FAIL;
        else                         state_d = NEXT;
      end
      NEXT:    state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: phase-start pulses, watchdog, key counter and text screen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      dec_start_q  <= 1'b0;
      wdog_q       <= '0;
      key_q        <= KEY_FIRST;
      bad_char_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      init_start_q <= (state_d == INIT) && (state_q != INIT);
      shuf_start_q <= (state_d == SHUF) && (state_q != SHUF);
      dec_start_q  <= (state_d == DEC)  && (state_q != DEC);

      if (state_d != state_q) wdog_q <= '0;
      else if (in_phase)      wdog_q <= wdog_q + WDOG_W'(1);

      if (start_accept)                               key_q <= KEY_FIRST;
      else if (state_q == NEXT)                       key_q <= key_q + KEY_W'(1);
      else if ((state_d == FAIL) && (state_q != FAIL)) key_q <= KEY_LAST;

      // A single non-text byte condemns the whole key, so the flag only clears
      // when a fresh decrypt pass begins.
      if ((state_d == DEC) && (state_q != DEC))
        bad_char_q <= 1'b0;
      else if ((state_q == DEC) && d_wren && !is_text(d_data))
        bad_char_q <= 1'b1;

      if (start_accept)   timeout_q <= 1'b0;
      else if (wdog_trip) timeout_q <= 1'b1;
    end
  end

  // Only the phase that owns the current state ever reaches the S-memory port.
  always_comb begin
    s_addr = 8'h00;
    s_data = 8'h00;
    s_wren = 1'b0;
    case (state_q)
      INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      SHUF: begin
        s_addr = shuf_addr;
        s_data = shuf_data;
        s_wren = shuf_wren;
      end
      DEC: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wren = dec_wren;
      end
      default: ;
    endcase
  end

  assign init_start  = init_start_q;
  assign shuf_start  = shuf_start_q;
  assign dec_start   = dec_start_q;
  assign secret_key  = key_q;
  assign busy        = (state_q == INIT) || (state_q == SHUF) || (state_q == DEC) ||
                       (state_q == CHECK) || (state_q == NEXT);
  assign found       = (state_q == FOUND);
  assign failed      = (state_q == FAIL);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: stub phase FSMs, a key-search reference model,
// a scoreboard of search outcomes and a cycle-level S-memory grant monitor.
module tb_rc4_key_search_ctrl;

  localparam int          KEY_W     = 24;
  localparam logic [23:0] KEY_FIRST = 24'h000000;
  localparam logic [23:0] KEY_LAST  = 24'h00024C;
  localparam int          TIMEOUT   = 40;

  localparam int M_ALL_A  = 0;
  localparam int M_LOW41  = 1;
  localparam int M_ALL_7B = 2;
  localparam int M_RAND   = 3;

  typedef struct {
    logic        found;
    logic        failed;
    logic        tmo;
    logic [23:0] key;
    int          inits;
    int          shufs;
    int          decs;
  } exp_t;

  logic        clk, rst_n, start;
  logic        init_start, init_done, shuf_start, shuf_done, dec_start, dec_done;
  logic [7:0]  init_addr, init_data, shuf_addr, shuf_data, dec_addr, dec_data;
  logic        init_wren, shuf_wren, dec_wren;
  logic [7:0]  s_addr, s_data;
  logic        s_wren;
  logic        d_wren;
  logic [7:0]  d_data;
  logic [23:0] secret_key;
  logic        busy, found, failed, timeout_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  exp_t        sb[$];

  int          mode      = M_ALL_A;
  logic [31:0] seed      = 32'h1234_5678;
  logic [23:0] target    = 24'h0;
  int          msg_len   = 4;
  int          lat_init  = 2;
  int          lat_shuf  = 2;
  logic        hang_shuf = 1'b0;
  logic        force_wren = 1'b0;

  rc4_key_search_ctrl #(
    .KEY_W(KEY_W), .KEY_FIRST(KEY_FIRST), .KEY_LAST(KEY_LAST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(rst_n), .start(start),
    .init_start(init_start), .init_done(init_done),
    .shuf_start(shuf_start), .shuf_done(shuf_done),
    .dec_start(dec_start), .dec_done(dec_done),
    .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
    .shuf_addr(shuf_addr), .shuf_data(shuf_data), .shuf_wren(shuf_wren),
    .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren),
    .d_wren(d_wren), .d_data(d_data),
    .secret_key(secret_key), .busy(busy), .found(found), .failed(failed),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic printable(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  function automatic logic [7:0] good_byte(input logic [31:0] h);
    int idx;
    idx = int'(h % 32'd27);
    return (idx == 26) ? 8'h20 : 8'(32'h61 + 32'(idx));
  endfunction

  function automatic logic [7:0] bad_byte(input logic [31:0] h);
    case (h[2:0])
      3'd0:    return 8'h60;
      3'd1:    return 8'h7B;
      3'd2:    return 8'h41;
      3'd3:    return 8'h00;
      3'd4:    return 8'hFF;
      3'd5:    return 8'h1F;
      3'd6:    return 8'h21;
      default: return 8'h5A;
    endcase
  endfunction

  // Byte i of the message that key k decrypts to, under the current scenario.
  function automatic logic [7:0] gen_byte(input logic [23:0] k, input int i);
    logic [31:0] h;
    int          pos;
    h = seed ^ ({8'h00, k} * 32'h9E37_79B1) ^ (32'(i) * 32'h85EB_CA6B);
    h = h ^ (h >> 15);
    h = h * 32'h2C1B_3C6D;
    h = h ^ (h >> 12);
    pos = int'({8'h00, k} % 32'(msg_len));
    case (mode)
      M_ALL_A:  return 8'h61;
      M_LOW41:  return (k < 24'h000249) ? 8'h41 : good_byte(h);
      M_ALL_7B: return 8'h7B;
      default:  return ((k < target) && (i == pos)) ? bad_byte(h) : good_byte(h);
    endcase
  endfunction

  function automatic exp_t model_search();
    exp_t e;
    int   tries;
    logic ok;
    e.found = 1'b0; e.failed = 1'b1; e.tmo = 1'b0; e.key = KEY_LAST;
    tries = 0;
    for (int unsigned k = 32'(KEY_FIRST); k <= 32'(KEY_LAST); k++) begin
      tries++;
      ok = 1'b1;
      for (int i = 0; i < msg_len; i++)
        if (!printable(gen_byte(k[23:0], i))) ok = 1'b0;
      if (ok) begin
        e.found = 1'b1; e.failed = 1'b0; e.key = k[23:0];
        break;
      end
    end
    e.inits = tries; e.shufs = tries; e.decs = tries;
    return e;
  endfunction

  // ---------------- phase FSM stubs ----------------
  initial begin
    init_done = 1'b0;
    forever begin
      @(negedge clk);
      if (init_start) begin
        int n;
        n = 0;
        while (n < lat_init && rst_n) begin @(negedge clk); n++; end
        if (rst_n) begin init_done = 1'b1; @(negedge clk); init_done = 1'b0; end
      end
    end
  end

  initial begin
    shuf_done = 1'b0;
    forever begin
      @(negedge clk);
      if (shuf_start) begin
        int n;
        n = 0;
        while (n < lat_shuf && rst_n) begin @(negedge clk); n++; end
        if (rst_n && !hang_shuf) begin shuf_done = 1'b1; @(negedge clk); shuf_done = 1'b0; end
      end
    end
  end

  initial begin
    dec_done = 1'b0; d_wren = 1'b0; d_data = 8'h00;
    forever begin
      @(negedge clk);
      if (dec_start) begin
        logic [23:0] k;
        k = secret_key;
        for (int i = 0; i < msg_len && rst_n; i++) begin
          d_wren = 1'b1;
          d_data = gen_byte(k, i);
          @(negedge clk);
        end
        d_wren = 1'b0;
        if (rst_n) begin dec_done = 1'b1; @(negedge clk); dec_done = 1'b0; end
      end
    end
  end

  // Requester traffic on all three S-memory ports, every cycle.
  initial begin
    init_addr = 8'h00; init_data = 8'h00; init_wren = 1'b0;
    shuf_addr = 8'h00; shuf_data = 8'h00; shuf_wren = 1'b0;
    dec_addr  = 8'h00; dec_data  = 8'h00; dec_wren  = 1'b0;
    forever begin
      @(negedge clk);
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = force_wren | 1'($urandom);
      shuf_addr = 8'($urandom); shuf_data = 8'($urandom); shuf_wren = force_wren | 1'($urandom);
      dec_addr  = 8'($urandom); dec_data  = 8'($urandom); dec_wren  = force_wren | 1'($urandom);
    end
  end

  // ---------------- monitors ----------------
  // Grant owner follows the phase handshakes: a phase owns the port from its start
  // pulse until its done pulse is taken; nobody owns it otherwise.
  initial begin
    int          ph;
    logic        sd_i, sd_s, sd_d;
    logic [16:0] want;
    ph = 0;
    forever begin
      @(posedge clk);
      sd_i = init_done; sd_s = shuf_done; sd_d = dec_done;
      #1;
      if (!rst_n || !busy)                                        ph = 0;
      else if (init_start)                                        ph = 1;
      else if (shuf_start)                                        ph = 2;
      else if (dec_start)                                         ph = 3;
      else if ((ph == 1 && sd_i) || (ph == 2 && sd_s) || (ph == 3 && sd_d)) ph = 0;
      case (ph)
        1:       want = {init_wren, init_addr, init_data};
        2:       want = {shuf_wren, shuf_addr, shuf_data};
        3:       want = {dec_wren, dec_addr, dec_data};
        default: want = 17'h0;
      endcase
      check("s_mem_grant", 32'({s_wren, s_addr, s_data}), 32'(want));
    end
  end

  // Scoreboard: each completed search (busy falling) is compared with the oldest
  // queued expectation.
  initial begin
    exp_t e;
    logic prev_busy;
    int   ic, sc, dc;
    prev_busy = 1'b0; ic = 0; sc = 0; dc = 0;
    forever begin
      @(negedge clk);
      if (start) begin ic = 0; sc = 0; dc = 0; end
      if (init_start) ic++;
      if (shuf_start) sc++;
      if (dec_start)  dc++;
      if (rst_n && prev_busy && !busy) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: search ended with no expectation queued (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("found",        32'(found),       32'(e.found));
          check("failed",       32'(failed),      32'(e.failed));
          check("timeout_err",  32'(timeout_err), 32'(e.tmo));
          check("secret_key",   32'(secret_key),  32'(e.key));
          check("init_pulses",  32'(ic),          32'(e.inits));
          check("shuf_pulses",  32'(sc),          32'(e.shufs));
          check("dec_pulses",   32'(dc),          32'(e.decs));
        end
      end
      prev_busy = busy && rst_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_start();
    repeat (4) @(negedge clk);
    @(posedge clk); #3; start = 1'b1;
    @(posedge clk); #3; start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40000) begin @(negedge clk); n++; end
    if (busy) begin
      n_checks++;
      $display("FAIL search_hang: busy still 1 after %0d cycles", n);
      @(posedge clk); #3; rst_n = 1'b0;
      @(posedge clk); #3; rst_n = 1'b1;
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       32'(busy),        32'h0);
    check({tag, "_found"},      32'(found),       32'h0);
    check({tag, "_failed"},     32'(failed),      32'h0);
    check({tag, "_timeout"},    32'(timeout_err), 32'h0);
    check({tag, "_key"},        32'(secret_key),  32'(KEY_FIRST));
    check({tag, "_starts"},     32'({init_start, shuf_start, dec_start}), 32'h0);
    check({tag, "_s_port"},     32'({s_wren, s_addr, s_data}), 32'h0);
  endtask

  initial begin
    exp_t e;
    int   n, t0, t1;
    rst_n = 1'b0; start = 1'b0; force_wren = 1'b1;
    repeat (3) @(posedge clk); #3;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // One key, every byte 'a'.
    mode = M_ALL_A; msg_len = 32; lat_init = 10; lat_shuf = 10;
    sb.push_back(model_search());
    issue_start(); wait_idle();

    // Uppercase bytes until key 0x249.
    mode = M_LOW41; msg_len = 4; lat_init = 2; lat_shuf = 2; force_wren = 1'b0;
    sb.push_back(model_search());
    issue_start(); wait_idle();

    // Every key yields '{' (one past 'z'): range is exhausted.
    mode = M_ALL_7B; msg_len = 3; lat_init = 1; lat_shuf = 1; force_wren = 1'b1;
    sb.push_back(model_search());
    issue_start(); wait_idle();

    // Randomised scenarios: random messages, target key, lengths and latencies.
    mode = M_RAND;
    for (int r = 0; r < 4; r++) begin
      seed       = $urandom;
      target     = 24'($urandom_range(0, 12));
      msg_len    = $urandom_range(1, 8);
      lat_init   = $urandom_range(0, 6);
      lat_shuf   = $urandom_range(0, 6);
      force_wren = 1'($urandom);
      sb.push_back(model_search());
      issue_start(); wait_idle();
    end

    // Done arriving in the watchdog's last cycle still advances.
    seed = $urandom; target = 24'h1; msg_len = 5; lat_shuf = 2; lat_init = TIMEOUT - 1;
    sb.push_back(model_search());
    issue_start(); wait_idle();

    // One cycle later the watchdog fires in INIT.
    lat_init = TIMEOUT;
    e.found = 1'b0; e.failed = 1'b1; e.tmo = 1'b1; e.key = KEY_LAST;
    e.inits = 1; e.shufs = 0; e.decs = 0;
    sb.push_back(e);
    issue_start(); wait_idle();

    // Shuffle never finishes: failure exactly TIMEOUT cycles after shuf_start.
    lat_init = 2; hang_shuf = 1'b1;
    e.found = 1'b0; e.failed = 1'b1; e.tmo = 1'b1; e.key = KEY_LAST;
    e.inits = 1; e.shufs = 1; e.decs = 0;
    sb.push_back(e);
    issue_start();
    n = 0;
    while (!shuf_start && n < 200) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!failed && n < 200) begin @(negedge clk); n++; end
    t1 = cyc;
    check("timeout_latency", 32'(t1 - t0), 32'(TIMEOUT));
    wait_idle();
    hang_shuf = 1'b0;

    // Reset while decrypting key 3, then a fresh search restarts at KEY_FIRST.
    mode = M_RAND; seed = $urandom; target = 24'h5; msg_len = 6; force_wren = 1'b1;
    issue_start();
    n = 0;
    while (!(dec_start && secret_key == 24'h3) && n < 2000) begin @(negedge clk); n++; end
    check("reached_dec_key3", 32'(dec_start && secret_key == 24'h3), 32'h1);
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (2) @(posedge clk); #3; rst_n = 1'b1;
    sb.push_back(model_search());
    issue_start(); wait_idle();

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL sb_leftover: %0d expectations never matched", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
